// File: rtl/lut_mem_core.sv
// lut_mem_core: small LUT-RAM mapped into the daisy-chained register bus
// at BASE_ADDR, with a second word-addressed user port into the fabric.
// Bus traffic outside the window passes through with one cycle of latency.
module lut_mem_core #(
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned WIDTH     = 16,
  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  // upstream bus
  input  logic [15:0]      addr_i,
  input  logic [15:0]      wdata_i,
  input  logic [15:0]      rdata_i,
  input  logic             rw_i,
  input  logic             valid_i,
  // downstream bus
  output logic [15:0]      addr_o,
  output logic [15:0]      wdata_o,
  output logic [15:0]      rdata_o,
  output logic             rw_o,
  output logic             valid_o,
  // user port
  input  logic [AW-1:0]    user_addr,
  input  logic [WIDTH-1:0] user_wdata,
  input  logic             user_we,
  output logic [WIDTH-1:0] user_rdata
);

  localparam logic [16:0] WIN_LO    = 17'(BASE_ADDR);
  localparam logic [16:0] WIN_DEPTH = 17'(DEPTH);

  // Storage: not reset, powers up all-zero.
  logic [WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

  // Output pipeline registers.
  logic [15:0]      addr_q;
  logic [15:0]      wdata_q;
  logic [15:0]      rdata_q;
  logic             rw_q;
  logic             valid_q;
  logic [WIDTH-1:0] user_rdata_q;

  logic [15:0]      rdata_d;
  logic [WIDTH-1:0] user_rdata_d;

  // Window decode. The offset is taken 17 bits wide: an address below the
  // base borrows into a huge value, and a window ending at 0xFFFF never
  // wraps, so a single unsigned compare covers both ends.
  logic [16:0]   off_full;
  logic          in_window;
  logic          bus_hit;
  logic [AW-1:0] bus_off;
  logic          bus_we;
  logic          user_ok;
  logic          user_wr;
  logic [WIDTH-1:0] bus_word;

  assign off_full  = {1'b0, addr_i} - WIN_LO;
  assign in_window = off_full < WIN_DEPTH;
  assign bus_hit   = valid_i && in_window;
  assign bus_off   = off_full[AW-1:0];
  // A bus write sampled on a reset edge is dropped along with the transaction.
  assign bus_we    = bus_hit && rw_i && !rst;

  // User addresses past the end of the array read as zero and never write.
  generate
    if ((2 ** AW) == DEPTH) begin : g_user_full
      assign user_ok = 1'b1;
    end else begin : g_user_partial
      assign user_ok = user_addr < AW'(DEPTH);
    end
  endgenerate

  assign user_wr = user_we && user_ok;

  // Memory writes. The user write is issued last so it overrides a bus
  // write to the same word in the same cycle.
  always_ff @(posedge clk) begin
    if (bus_we) begin
      mem_q[bus_off] <= wdata_i[WIDTH-1:0];
    end
    if (user_wr) begin
      mem_q[user_addr] <= user_wdata;
    end
  end

  // Next-state read data: pre-write contents for both ports, so a read
  // colliding with a write returns the old word.
  always_comb begin
    bus_word     = mem_q[bus_off];
    rdata_d      = rdata_i;
    user_rdata_d = '0;
    if (bus_hit && !rw_i) begin
      rdata_d = 16'(bus_word);
    end
    if (user_ok) begin
      user_rdata_d = mem_q[user_addr];
    end
  end

  // One-cycle bus pipeline and registered user read; all cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      rw_q         <= 1'b0;
      valid_q      <= 1'b0;
      user_rdata_q <= '0;
    end else begin
      addr_q       <= addr_i;
      wdata_q      <= wdata_i;
      rdata_q      <= rdata_d;
      rw_q         <= rw_i;
      valid_q      <= valid_i;
      user_rdata_q <= user_rdata_d;
    end
  end

  assign addr_o     = addr_q;
  assign wdata_o    = wdata_q;
  assign rdata_o    = rdata_q;
  assign rw_o       = rw_q;
  assign valid_o    = valid_q;
  assign user_rdata = user_rdata_q;

endmodule

// File: tb/tb_lut_mem_core.sv
// Testbench for lut_mem_core: three instances (low window, window at the
// top of address space, narrow non-power-of-two memory) share one stimulus
// stream; a behavioural model pushes expected outputs, popped after each edge.
module tb_lut_mem_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] addr, wdata, rdi;
  logic        rw, valid;
  logic [3:0]  ua;
  logic [15:0] uwd;
  logic        uwe;

  logic [2:0][15:0] ao, wo, ro, ur;
  logic [2:0]       rwo, vo;

  assign ur[2][15:8] = '0;

  lut_mem_core #(.BASE_ADDR('h0010), .DEPTH(16), .WIDTH(16)) u0 (
    .clk(clk), .rst(rst),
    .addr_i(addr), .wdata_i(wdata), .rdata_i(rdi), .rw_i(rw), .valid_i(valid),
    .addr_o(ao[0]), .wdata_o(wo[0]), .rdata_o(ro[0]), .rw_o(rwo[0]), .valid_o(vo[0]),
    .user_addr(ua), .user_wdata(uwd), .user_we(uwe), .user_rdata(ur[0])
  );

  lut_mem_core #(.BASE_ADDR('hFFF0), .DEPTH(16), .WIDTH(16)) u1 (
    .clk(clk), .rst(rst),
    .addr_i(addr), .wdata_i(wdata), .rdata_i(rdi), .rw_i(rw), .valid_i(valid),
    .addr_o(ao[1]), .wdata_o(wo[1]), .rdata_o(ro[1]), .rw_o(rwo[1]), .valid_o(vo[1]),
    .user_addr(ua), .user_wdata(uwd), .user_we(uwe), .user_rdata(ur[1])
  );

  lut_mem_core #(.BASE_ADDR('h0100), .DEPTH(12), .WIDTH(8)) u2 (
    .clk(clk), .rst(rst),
    .addr_i(addr), .wdata_i(wdata), .rdata_i(rdi), .rw_i(rw), .valid_i(valid),
    .addr_o(ao[2]), .wdata_o(wo[2]), .rdata_o(ro[2]), .rw_o(rwo[2]), .valid_o(vo[2]),
    .user_addr(ua), .user_wdata(uwd[7:0]), .user_we(uwe), .user_rdata(ur[2][7:0])
  );

  // Instance configuration as seen by the model.
  int          base  [3] = '{'h0010, 'hFFF0, 'h0100};
  int          depth [3] = '{16, 16, 12};
  logic [15:0] mask  [3] = '{16'hFFFF, 16'hFFFF, 16'h00FF};
  logic [15:0] mdl   [3][16];

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [15:0] urd;
    logic        rw;
    logic        valid;
  } exp_t;

  exp_t sbq[$];

  int vectors    = 0;
  int miscompares = 0;

  logic [15:0] atab [13] = '{16'h000F, 16'h0010, 16'h0015, 16'h001F, 16'h0020,
                             16'hFFEF, 16'hFFF0, 16'hFFFF, 16'h0000, 16'h00FF,
                             16'h0100, 16'h010B, 16'h010C};

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge: model predicts each instance's outputs, then they are
  // popped and compared one time unit after the edge.
  task automatic step();
    exp_t e;
    int a, off, u;
    logic hit;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      a   = int'(addr);
      off = a - base[k];
      u   = int'(ua);
      hit = valid && (a >= base[k]) && (a < base[k] + depth[k]);
      if (rst) begin
        e = '0;
      end else begin
        e.addr  = addr;
        e.wdata = wdata;
        e.rw    = rw;
        e.valid = valid;
        e.rdata = (hit && !rw) ? mdl[k][off] : rdi;
        e.urd   = (u < depth[k]) ? mdl[k][u] : 16'h0000;
        if (hit && rw) mdl[k][off] = wdata & mask[k];
        if (uwe && (u < depth[k])) mdl[k][u] = uwd & mask[k];
      end
      sbq.push_back(e);
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      e = sbq.pop_front();
      check_eq($sformatf("u%0d.addr_o", k),     ao[k],          e.addr);
      check_eq($sformatf("u%0d.wdata_o", k),    wo[k],          e.wdata);
      check_eq($sformatf("u%0d.rdata_o", k),    ro[k],          e.rdata);
      check_eq($sformatf("u%0d.rw_o", k),       16'(rwo[k]),    16'(e.rw));
      check_eq($sformatf("u%0d.valid_o", k),    16'(vo[k]),     16'(e.valid));
      check_eq($sformatf("u%0d.user_rdata", k), ur[k],          e.urd);
    end
    if (valid || uwe)
      $display("txn rst=%b addr=%h rw=%b wdata=%h rdata_i=%h ua=%0d uwe=%b uwd=%h -> rdata_o=%h/%h/%h user_rdata=%h/%h/%h",
               rst, addr, rw, wdata, rdi, ua, uwe, uwd, ro[0], ro[1], ro[2], ur[0], ur[1], ur[2]);
  endtask

  task automatic xact(input logic [15:0] a, input logic [15:0] wd, input logic [15:0] rd,
                      input logic w, input logic v,
                      input logic [3:0] u_a, input logic [15:0] u_wd, input logic u_we);
    @(negedge clk);
    addr = a; wdata = wd; rdi = rd; rw = w; valid = v;
    ua = u_a; uwd = u_wd; uwe = u_we;
    step();
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
    xact(a, d, 16'h0000, 1'b1, 1'b1, 4'd0, 16'h0000, 1'b0);
  endtask

  task automatic bus_rd(input logic [15:0] a, input logic [15:0] rd);
    xact(a, 16'h0000, rd, 1'b0, 1'b1, 4'd0, 16'h0000, 1'b0);
  endtask

  task automatic idle(input logic [3:0] u_a);
    xact(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, u_a, 16'h0000, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 16; i++)
        mdl[k][i] = 16'h0000;
    rst = 1'b1;
    addr = 16'h0013; wdata = 16'h1111; rdi = 16'h2222; rw = 1'b1; valid = 1'b1;
    ua = 4'd0; uwd = 16'h0000; uwe = 1'b0;

    // Reset state: outputs held at zero, and the write seen on reset edges is dropped.
    step();
    step();
    @(negedge clk);
    rst = 1'b0; valid = 1'b0;
    step();

    // Write then read back through the bus and the user port.
    bus_wr(16'h0013, 16'hBEEF);
    idle(4'd0);
    idle(4'd0);
    bus_rd(16'h0013, 16'h5555);
    check_eq("tp_rd13_rdata", ro[0], 16'hBEEF);
    check_eq("tp_rd13_addr",  ao[0], 16'h0013);
    check_eq("tp_rd13_valid", 16'(vo[0]), 16'h0001);
    check_eq("tp_rd13_passthru_u1", ro[1], 16'h5555);
    idle(4'd3);
    check_eq("tp_user3", ur[0], 16'hBEEF);

    // Window edges and pass-through.
    bus_rd(16'h000F, 16'h1234);
    check_eq("tp_miss_below", ro[0], 16'h1234);
    bus_rd(16'h0020, 16'h1234);
    check_eq("tp_miss_above", ro[0], 16'h1234);
    bus_rd(16'h0010, 16'h1234);
    check_eq("tp_hit_first", ro[0], 16'h0000);
    bus_rd(16'h001F, 16'h1234);
    check_eq("tp_hit_last", ro[0], 16'h0000);

    // Window touching the top of address space.
    bus_wr(16'hFFFF, 16'h00AA);
    bus_rd(16'hFFFF, 16'h4321);
    check_eq("tp_top_rd", ro[1], 16'h00AA);
    bus_rd(16'h0000, 16'h7777);
    check_eq("tp_top_nowrap", ro[1], 16'h7777);

    // Narrow memory: truncated write, zero-extended read.
    bus_wr(16'h0100, 16'h1234);
    bus_rd(16'h0100, 16'h9999);
    check_eq("tp_w8_bus", ro[2], 16'h0034);
    idle(4'd0);
    check_eq("tp_w8_user", ur[2], 16'h0034);
    xact(16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 4'd13, 16'hABCD, 1'b1);
    idle(4'd13);
    check_eq("tp_user_oob", ur[2], 16'h0000);
    check_eq("tp_user13_u0", ur[0], 16'hABCD);

    // Collision: user write beats bus write to the same word.
    xact(16'h0015, 16'h1111, 16'h0000, 1'b1, 1'b1, 4'd5, 16'h2222, 1'b1);
    bus_rd(16'h0015, 16'h0000);
    check_eq("tp_collision", ro[0], 16'h2222);

    // Read-during-write returns old data on both ports.
    xact(16'h0016, 16'h0000, 16'h0000, 1'b0, 1'b1, 4'd6, 16'h6666, 1'b1);
    check_eq("tp_rdw_bus_old", ro[0], 16'h0000);
    bus_rd(16'h0016, 16'h0000);
    check_eq("tp_rdw_bus_new", ro[0], 16'h6666);
    xact(16'h0017, 16'h7777, 16'h0000, 1'b1, 1'b1, 4'd7, 16'h0000, 1'b0);
    check_eq("tp_rdw_user_old", ur[0], 16'h0000);
    idle(4'd7);
    check_eq("tp_rdw_user_new", ur[0], 16'h7777);

    // Back-to-back mixed traffic checked against the model.
    for (int i = 0; i < 40; i++) begin
      xact(atab[$urandom_range(0, 12)], 16'($urandom), 16'($urandom),
           1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
           4'($urandom_range(0, 15)), 16'($urandom), $urandom_range(0, 3) == 0);
    end

    // Asynchronous reset mid-cycle, one cycle after a write hit.
    bus_wr(16'h0019, 16'h1357);
    bus_wr(16'h0018, 16'h0808);
    #3;
    rst = 1'b1;
    addr = 16'h0019; wdata = 16'h0909; rw = 1'b1; valid = 1'b1; uwe = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("async_rst_u%0d_addr", k),  ao[k], 16'h0000);
      check_eq($sformatf("async_rst_u%0d_wdata", k), wo[k], 16'h0000);
      check_eq($sformatf("async_rst_u%0d_rdata", k), ro[k], 16'h0000);
      check_eq($sformatf("async_rst_u%0d_valid", k), 16'(vo[k]), 16'h0000);
      check_eq($sformatf("async_rst_u%0d_rw", k),    16'(rwo[k]), 16'h0000);
      check_eq($sformatf("async_rst_u%0d_user", k),  ur[k], 16'h0000);
    end
    step();
    @(negedge clk);
    rst = 1'b0; valid = 1'b0;
    step();
    check_eq("rst_valid_after", 16'(vo[0]), 16'h0000);
    bus_rd(16'h0018, 16'h0000);
    check_eq("rst_survive", ro[0], 16'h0808);
    bus_rd(16'h0019, 16'h0000);
    check_eq("rst_edge_write_dropped", ro[0], 16'h1357);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
